stage_gen: RTL

STAGE_GEN -- requirements
Module: stage_gen

---
 rtl/stage_pkg.sv | 30 +++
 rtl/lfsr16.sv | 23 ++
 rtl/stage_gen.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/stage_pkg.sv
// Shared definitions for the stage generator and the stage reader:
// record layout, field bit positions and the generator state encoding.
package stage_pkg;

   localparam int POS_W  = 16;
   localparam int STAT_W = 4;
   localparam int BLK_W  = 3 * POS_W + STAT_W;

   // Bit positions of each field inside a packed record
   localparam int LEFT_LSB   = 36;
   localparam int RIGHT_LSB  = 20;
   localparam int HEIGHT_LSB = 4;
   localparam int STAT_LSB   = 0;

   typedef struct packed {
      logic [POS_W-1:0]  left;
      logic [POS_W-1:0]  right;
      logic [POS_W-1:0]  height;
      logic [STAT_W-1:0] stat;
   } blk_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GEN,
      ST_WRITE,
      ST_WAIT,
      ST_DONE
   } state_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (mask 16'hB400). A zero seed would lock up, so it is
// replaced by 1.
module lfsr16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] seed,
   input  logic        advance,
   output logic [15:0] value
);

   logic [15:0] seed_nz;

   assign seed_nz = (seed == 16'h0000) ? 16'h0001 : seed;

   // Load seed on reset, step one position per advance request
   always_ff @(posedge clk) begin
      if (!rst_n)
         value <= seed_nz;
      else if (advance)
         value <= value[0] ? ((value >> 1) ^ 16'hB400) : (value >> 1);
   end

endmodule

// File: rtl/stage_gen.sv
// Stage generator: produces platform records (left, right, height, stat)
// into an external ring RAM, tracks the unconsumed fill level and stops
// once the horizontal coordinate space is used up.
module stage_gen
   import stage_pkg::*;
#(
   parameter int          BLK_BITS  = 52,
   parameter int          POS_DIGIT = 16,
   parameter int          STG_DEPTH = 8,
   parameter int          FIRST_W   = 400,
   parameter int          FLOOR_H   = 100,
   parameter int          MIN_W     = 64,
   parameter int          W_BITS    = 7,
   parameter int          MIN_GAP   = 16,
   parameter int          G_BITS    = 6,
   parameter int          MIN_H     = 40,
   parameter int          H_BITS    = 7,
   parameter logic [15:0] SEED      = 16'hACE1
) (
   input  logic                           i_clk_pix,
   input  logic                           i_rst_n,
   input  logic                           i_start,
   input  logic                           i_consume,
   output logic                           o_wr_en,
   output logic [$clog2(STG_DEPTH)-1:0]   o_wr_addr,
   output logic [BLK_BITS-1:0]            o_wr_data,
   output logic [$clog2(STG_DEPTH):0]     o_level,
   output logic                           o_full,
   output logic                           o_done
);

   localparam int AW  = $clog2(STG_DEPTH);
   localparam int LW  = AW + 1;
   localparam int PW1 = POS_DIGIT + 1;

   state_t                 state_q, state_d;
   logic [AW-1:0]          wr_addr_q;
   logic [LW-1:0]          level_q, level_d;
   logic [BLK_BITS-1:0]    rec_q;
   logic [POS_DIGIT-1:0]   prev_right_q;
   logic                   first_q;
   logic                   exh_q;
   logic                   done_q;

   logic [15:0]            lfsr_v;
   logic                   lfsr_adv;
   logic                   wr;
   logic                   consume_eff;

   logic [PW1-1:0]         gap, width, left_w, right_w;
   logic [POS_DIGIT-1:0]   hgt, right_c;
   logic                   ovf;
   logic                   unused_bits;

   assign wr       = (state_q == ST_WRITE);
   assign lfsr_adv = (state_q == ST_GEN) && !first_q;

   lfsr16 u_lfsr (
      .clk     (i_clk_pix),
      .rst_n   (i_rst_n),
      .seed    (SEED),
      .advance (lfsr_adv),
      .value   (lfsr_v)
   );

   // Next-record arithmetic, one bit wider than a coordinate to catch overflow
   always_comb begin
      gap     = PW1'(MIN_GAP) + PW1'(lfsr_v[G_BITS-1:0]);
      width   = PW1'(MIN_W) + PW1'(lfsr_v[W_BITS+7:8]);
      hgt     = POS_DIGIT'(MIN_H) + POS_DIGIT'(lfsr_v[H_BITS-1:0]);
      left_w  = {1'b0, prev_right_q} + PW1'(1) + gap;
      right_w = left_w + width - PW1'(1);
      ovf     = right_w[POS_DIGIT];
      right_c = ovf ? '1 : right_w[POS_DIGIT-1:0];
   end

   assign unused_bits = ^{lfsr_v, left_w};

   // Fill level: a write and a consume in the same cycle cancel; a consume
   // with nothing stored and no coincident write is ignored
   always_comb begin
      consume_eff = i_consume && ((level_q != '0) || wr);
      level_d     = level_q;
      if (wr && !consume_eff)
         level_d = level_q + LW'(1);
      else if (!wr && consume_eff)
         level_d = level_q - LW'(1);
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (i_start) state_d = ST_GEN;
         ST_GEN:   state_d = ST_WRITE;
         ST_WRITE: begin
            if (exh_q)
               state_d = ST_DONE;
            else if (level_d == LW'(STG_DEPTH))
               state_d = ST_WAIT;
            else
               state_d = ST_GEN;
         end
         ST_WAIT:  if (level_q < LW'(STG_DEPTH)) state_d = ST_GEN;
         ST_DONE:  state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // State, record build, write address and level registers
   always_ff @(posedge i_clk_pix) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         wr_addr_q    <= '0;
         level_q      <= '0;
         rec_q        <= '0;
         prev_right_q <= '0;
         first_q      <= 1'b1;
         exh_q        <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         if (state_q == ST_GEN) begin
            first_q <= 1'b0;
            if (first_q) begin
               rec_q        <= {POS_DIGIT'(0), POS_DIGIT'(FIRST_W - 1),
                                POS_DIGIT'(FLOOR_H), 4'b0000};
               prev_right_q <= POS_DIGIT'(FIRST_W - 1);
            end else begin
               rec_q        <= {left_w[POS_DIGIT-1:0], right_c, hgt,
                                3'b000, lfsr_v[15]};
               prev_right_q <= right_c;
               exh_q        <= ovf;
            end
         end
         if (wr) begin
            wr_addr_q <= (wr_addr_q == AW'(STG_DEPTH - 1)) ? '0 : wr_addr_q + AW'(1);
            if (exh_q)
               done_q <= 1'b1;
         end
      end
   end

   assign o_wr_en   = wr;
   assign o_wr_addr = wr_addr_q;
   assign o_wr_data = rec_q;
   assign o_level   = level_q;
   assign o_full    = (level_q == LW'(STG_DEPTH));
   assign o_done    = done_q;

endmodule
